cpu_acc_seq: RTL and testbench

CPU_ACC_SEQ -- requirements
Module: cpu_acc_seq

---
 rtl/cpu_acc_seq.sv | 150 +++++++++++++++
 tb/tb_cpu_acc_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_acc_seq.sv
// CPU-to-internal bus access sequencer.
// Synchronizes the CPU chip enable, issues one internal request per CPU
// access, waits a bounded time for the acknowledge, returns read data and
// pulses a ready strobe once the access has completed or timed out.
module cpu_acc_seq #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              pce_,
    input  logic              prnw,
    input  logic [ADDR_W-1:0] pa,
    input  logic [DATA_W-1:0] pdi,
    output logic [DATA_W-1:0] pdo,
    output logic              rdyout,
    output logic              ireq,
    output logic              iwr,
    output logic [ADDR_W-1:0] ia,
    output logic [DATA_W-1:0] idi,
    input  logic              iack,
    input  logic [DATA_W-1:0] irdat,
    output logic              tmo_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic [9:0] TMO_CNT = 10'(TMO);

    state_t            state_q, state_d;
    logic              pce_meta_q;
    logic              pce_s_q;
    logic [9:0]        cnt_q, cnt_d;
    logic [9:0]        cnt_inc;
    logic [ADDR_W-1:0] ia_q, ia_d;
    logic [DATA_W-1:0] idi_q, idi_d;
    logic              iwr_q, iwr_d;
    logic [DATA_W-1:0] pdo_q, pdo_d;
    logic              ireq_q, ireq_d;
    logic              rdyout_q, rdyout_d;
    logic              tmo_err_q, tmo_err_d;

    assign cnt_inc = cnt_q + 10'd1;

    // Next-state and next-output computation; the pulse outputs are decoded
    // from the transition so that they appear registered in the target state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ia_d      = ia_q;
        idi_d     = idi_q;
        iwr_d     = iwr_q;
        pdo_d     = pdo_q;
        tmo_err_d = tmo_err_q;
        ireq_d    = 1'b0;
        rdyout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!pce_s_q) begin
                    ia_d      = pa;
                    idi_d     = pdi;
                    iwr_d     = ~prnw;
                    tmo_err_d = 1'b0;
                    cnt_d     = 10'd0;
                    ireq_d    = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ, WAIT: begin
                if (pce_s_q) begin
                    state_d = IDLE;
                end else if (iack) begin
                    if (!iwr_q) begin
                        pdo_d = irdat;
                    end
                    rdyout_d = 1'b1;
                    state_d  = DONE;
                end else if (state_q == REQ) begin
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_CNT) begin
                        tmo_err_d = 1'b1;
                        if (!iwr_q) begin
                            pdo_d = '1;
                        end
                        rdyout_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (pce_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, the chip-enable synchronizer and the registered outputs.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            pce_meta_q <= 1'b1;
            pce_s_q    <= 1'b1;
            cnt_q      <= 10'd0;
            ia_q       <= '0;
            idi_q      <= '0;
            iwr_q      <= 1'b0;
            pdo_q      <= '0;
            ireq_q     <= 1'b0;
            rdyout_q   <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pce_meta_q <= pce_;
            pce_s_q    <= pce_meta_q;
            cnt_q      <= cnt_d;
            ia_q       <= ia_d;
            idi_q      <= idi_d;
            iwr_q      <= iwr_d;
            pdo_q      <= pdo_d;
            ireq_q     <= ireq_d;
            rdyout_q   <= rdyout_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign pdo     = pdo_q;
    assign rdyout  = rdyout_q;
    assign ireq    = ireq_q;
    assign iwr     = iwr_q;
    assign ia      = ia_q;
    assign idi     = idi_q;
    assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_cpu_acc_seq.sv
// Testbench for cpu_acc_seq: directed scenarios plus randomized accesses,
// compared against a cycle-count model of a single CPU access.
module tb_cpu_acc_seq;

    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_;
    logic          pce_;
    logic          prnw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pdi;
    logic [DW-1:0] pdo;
    logic          rdyout;
    logic          ireq;
    logic          iwr;
    logic [AW-1:0] ia;
    logic [DW-1:0] idi;
    logic          iack;
    logic [DW-1:0] irdat;
    logic          tmo_err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model_pdo;

    cpu_acc_seq #(.ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_(rst_), .pce_(pce_), .prnw(prnw), .pa(pa), .pdi(pdi),
        .pdo(pdo), .rdyout(rdyout), .ireq(ireq), .iwr(iwr), .ia(ia), .idi(idi),
        .iack(iack), .irdat(irdat), .tmo_err(tmo_err)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU access. ack_at is the cycle (ireq cycle = 0) in which iack is
    // presented; abort_at >= 0 raises pce_ in that cycle; hold_extra keeps
    // pce_ low for extra cycles after the access.
    task automatic applyStimulus(input bit rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [DW-1:0] rdata, input int ack_at, input int abort_at,
                                 input int hold_extra);
        int lat;
        int n_ireq;
        int n_rdy;
        int rdy_at;
        int exp_rdy;
        int last;
        bit exp_tmo;
        bit acked;
        logic [DW-1:0] exp_pdo;

        @(negedge clk);
        prnw  = rnw;
        pa    = addr;
        pdi   = wdata;
        irdat = rdata;
        pce_  = 1'b0;
        lat   = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (ireq) lat = k;
        end
        checkOutput("ireq_latency", lat, 2);
        if (lat < 0) begin
            pce_ = 1'b1;
            return;
        end
        checkOutput("ia", ia, addr);
        checkOutput("iwr", iwr, !rnw);
        checkOutput("idi", idi, wdata);
        checkOutput("tmo_err_cleared", tmo_err, 0);
        checkOutput("rdy_at_ireq", rdyout, 0);

        acked   = (ack_at <= TMO);
        exp_rdy = (acked ? ack_at : TMO) + 1;
        exp_tmo = (abort_at < 0) && !acked;
        if (abort_at >= 0 || !rnw) exp_pdo = model_pdo;
        else if (acked)            exp_pdo = rdata;
        else                       exp_pdo = '1;

        n_ireq = 1;
        n_rdy  = 0;
        rdy_at = -1;
        last   = ((ack_at > exp_rdy) ? ack_at : exp_rdy) + hold_extra + 3;
        for (int c = 0; c <= last; c++) begin
            iack = (c == ack_at);
            if (abort_at >= 0 && c >= abort_at) pce_ = 1'b1;
            @(negedge clk);
            if (ireq) n_ireq++;
            if (rdyout) begin
                n_rdy++;
                rdy_at = c + 1;
            end
        end
        iack = 1'b0;
        checkOutput("pdo", pdo, exp_pdo);
        checkOutput("tmo_err", tmo_err, exp_tmo);
        if (abort_at < 0) checkOutput("rdy_cycle", rdy_at, exp_rdy);

        pce_ = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ireq) n_ireq++;
            if (rdyout) n_rdy++;
        end
        checkOutput("ireq_count", n_ireq, 1);
        checkOutput("rdy_count", n_rdy, (abort_at < 0) ? 1 : 0);
        checkOutput("pdo_after", pdo, exp_pdo);
        model_pdo = exp_pdo;
    endtask

    // Reset pulse in the middle of a read, then a fresh access on release.
    task automatic reset_mid_access(input logic [DW-1:0] rdata);
        int k_ireq;
        @(negedge clk);
        prnw  = 1'b1;
        pa    = 12'h3C3;
        irdat = rdata;
        pce_  = 1'b0;
        repeat (5) @(negedge clk);
        rst_ = 1'b0;
        #1;
        checkOutput("rst_ireq", ireq, 0);
        checkOutput("rst_rdy", rdyout, 0);
        checkOutput("rst_iwr", iwr, 0);
        checkOutput("rst_tmo", tmo_err, 0);
        checkOutput("rst_pdo", pdo, 0);
        checkOutput("rst_ia", ia, 0);
        checkOutput("rst_idi", idi, 0);
        model_pdo = '0;
        @(negedge clk);
        rst_    = 1'b1;
        k_ireq  = -1;
        for (int k = 0; k < 3 && k_ireq < 0; k++) begin
            @(negedge clk);
            if (ireq) k_ireq = k;
        end
        checkOutput("rst_reaccess", (k_ireq >= 0), 1);
        if (k_ireq >= 0) begin
            iack = 1'b1;
            @(negedge clk);
            iack = 1'b0;
            checkOutput("rst_reaccess_rdy", rdyout, 1);
            checkOutput("rst_reaccess_pdo", pdo, rdata);
            model_pdo = rdata;
        end
        pce_ = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Test sequence.
    initial begin
        rst_      = 1'b0;
        pce_      = 1'b1;
        prnw      = 1'b1;
        pa        = '0;
        pdi       = '0;
        irdat     = '0;
        iack      = 1'b0;
        model_pdo = '0;
        #2;
        checkOutput("reset_pdo", pdo, 0);
        checkOutput("reset_ireq", ireq, 0);
        checkOutput("reset_rdy", rdyout, 0);
        checkOutput("reset_tmo", tmo_err, 0);
        checkOutput("reset_ia", ia, 0);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(1'b1, 12'h123, 16'h0000, 16'hBEEF, 4, -1, 0);
        applyStimulus(1'b0, 12'h045, 16'h5A5A, 16'h1111, 1, -1, 0);
        applyStimulus(1'b1, 12'h0AA, 16'h0000, 16'h2222, 20, -1, 0);
        applyStimulus(1'b1, 12'h0AB, 16'h0000, 16'h3333, 0, -1, 0);
        applyStimulus(1'b1, 12'h0AC, 16'h0000, 16'h4444, 6, 1, 0);
        applyStimulus(1'b1, 12'h0AD, 16'h0000, 16'h5555, TMO, -1, 50);
        reset_mid_access(16'hC0DE);

        for (int i = 0; i < 25; i++) begin
            applyStimulus($urandom_range(0, 1), AW'($urandom), DW'($urandom), DW'($urandom),
                          $urandom_range(0, TMO + 4), -1, $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
